// File: rtl/booth_bist_driver_if.sv
// Operand/handshake bundle between the BIST driver (master) and the Booth multiplier (slave).
interface booth_bist_driver_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_start;
  logic               mul_busy;
  logic [2*WIDTH-1:0] mul_product;

  modport master (
    output mul_a,
    output mul_b,
    output mul_start,
    input  mul_busy,
    input  mul_product
  );

  modport slave (
    input  mul_a,
    input  mul_b,
    input  mul_start,
    output mul_busy,
    output mul_product
  );
endinterface

// File: rtl/booth_bist_driver.sv
// Self-test driver for the Booth multiplier: walks every signed operand pair,
// honours the busy handshake, checks each product against a golden signed
// product and reports done/pass/err_count.
// Optional macro BIST_FAIL_CAPTURE_EN: latch operands/product of the first
// failing pair of a run on fail_a/fail_b/fail_product (tied to 0 otherwise).
module booth_bist_driver #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                test_en,
  booth_bist_driver_if.master mul,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_count,
  output logic [WIDTH-1:0]    fail_a,
  output logic [WIDTH-1:0]    fail_b,
  output logic [2*WIDTH-1:0]  fail_product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_mul_a, w_mul_a_nxt;
  logic [WIDTH-1:0] r_mul_b, w_mul_b_nxt;
  logic             r_start, w_start_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [7:0]       r_err, w_err_nxt;
  logic [CW-1:0]    r_wait, w_wait_nxt;
  logic             r_tmo, w_tmo_nxt;

  logic [PW-1:0]    w_idx_inc;
  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_b_ext;
  logic [PW-1:0]    w_golden;
  logic             w_bad;
  logic             w_wait_expired;

`ifdef BIST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] r_fail_a, w_fail_a_nxt;
  logic [WIDTH-1:0] r_fail_b, w_fail_b_nxt;
  logic [PW-1:0]    r_fail_p, w_fail_p_nxt;
`endif

  // Low 2*WIDTH bits of a sign-extended product equal the truncated signed product.
  assign w_a_ext        = {{WIDTH{r_mul_a[WIDTH-1]}}, r_mul_a};
  assign w_b_ext        = {{WIDTH{r_mul_b[WIDTH-1]}}, r_mul_b};
  assign w_golden       = w_a_ext * w_b_ext;
  assign w_bad          = r_tmo | (mul.mul_product != w_golden);
  assign w_idx_inc      = r_idx + PW'(1);
  assign w_wait_expired = (r_wait == CW'(TIMEOUT - 1));

  // Next-state and next-output decode; a timeout diverts to CHECK with r_tmo set
  // so that error counting and advancing share one path.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mul_a_nxt = r_mul_a;
    w_mul_b_nxt = r_mul_b;
    w_start_nxt = 1'b0;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_wait_nxt  = r_wait;
    w_tmo_nxt   = r_tmo;
`ifdef BIST_FAIL_CAPTURE_EN
    w_fail_a_nxt = r_fail_a;
    w_fail_b_nxt = r_fail_b;
    w_fail_p_nxt = r_fail_p;
`endif
    if (!test_en && r_state != S_IDLE && r_state != S_FINISH) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_done_nxt = 1'b0;
          w_pass_nxt = 1'b0;
          if (test_en) begin
            w_idx_nxt   = '0;
            w_err_nxt   = '0;
            w_mul_a_nxt = '0;
            w_mul_b_nxt = '0;
            w_start_nxt = 1'b1;
            w_state_nxt = S_ISSUE;
`ifdef BIST_FAIL_CAPTURE_EN
            w_fail_a_nxt = '0;
            w_fail_b_nxt = '0;
            w_fail_p_nxt = '0;
`endif
          end
        end
        S_ISSUE: begin
          w_wait_nxt  = '0;
          w_tmo_nxt   = 1'b0;
          w_state_nxt = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (mul.mul_busy) begin
            w_wait_nxt  = '0;
            w_state_nxt = S_WAIT_DONE;
          end else if (w_wait_expired) begin
            w_tmo_nxt   = 1'b1;
            w_state_nxt = S_CHECK;
          end else begin
            w_wait_nxt = r_wait + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!mul.mul_busy) begin
            w_state_nxt = S_CHECK;
          end else if (w_wait_expired) begin
            w_tmo_nxt   = 1'b1;
            w_state_nxt = S_CHECK;
          end else begin
            w_wait_nxt = r_wait + CW'(1);
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            if (r_err != 8'hFF) begin
              w_err_nxt = r_err + 8'd1;
            end
`ifdef BIST_FAIL_CAPTURE_EN
            if (r_err == 8'd0) begin
              w_fail_a_nxt = r_mul_a;
              w_fail_b_nxt = r_mul_b;
              w_fail_p_nxt = r_tmo ? '0 : mul.mul_product;
            end
`endif
          end
          if (r_idx == '1) begin
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_nxt == 8'd0);
            w_state_nxt = S_FINISH;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_mul_a_nxt = w_idx_inc[PW-1:WIDTH];
            w_mul_b_nxt = w_idx_inc[WIDTH-1:0];
            w_start_nxt = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
        S_FINISH: begin
          if (!test_en) begin
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_wait  <= '0;
      r_tmo   <= 1'b0;
`ifdef BIST_FAIL_CAPTURE_EN
      r_fail_a <= '0;
      r_fail_b <= '0;
      r_fail_p <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_mul_a <= w_mul_a_nxt;
      r_mul_b <= w_mul_b_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_wait  <= w_wait_nxt;
      r_tmo   <= w_tmo_nxt;
`ifdef BIST_FAIL_CAPTURE_EN
      r_fail_a <= w_fail_a_nxt;
      r_fail_b <= w_fail_b_nxt;
      r_fail_p <= w_fail_p_nxt;
`endif
    end
  end

  assign mul.mul_a     = r_mul_a;
  assign mul.mul_b     = r_mul_b;
  assign mul.mul_start = r_start;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err;

`ifdef BIST_FAIL_CAPTURE_EN
  assign fail_a       = r_fail_a;
  assign fail_b       = r_fail_b;
  assign fail_product = r_fail_p;
`else
  assign fail_a       = '0;
  assign fail_b       = '0;
  assign fail_product = '0;
`endif

endmodule

// File: tb/tb_booth_bist_driver.sv
// Bench for booth_bist_driver: behavioural multiplier with random handshake
// timing, optional product corruption and a never-busy mode.
`timescale 1ns/1ps
module tb_booth_bist_driver;
  localparam int unsigned W   = 4;
  localparam int unsigned TMO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           test_en;
  logic           done;
  logic           pass;
  logic [7:0]     err_count;
  logic [W-1:0]   fail_a;
  logic [W-1:0]   fail_b;
  logic [2*W-1:0] fail_product;

  int n_cmp = 0;
  int n_bad = 0;

  booth_bist_driver_if #(.WIDTH(W)) mif ();

  booth_bist_driver #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .test_en(test_en), .mul(mif),
    .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_product(fail_product)
  );

  always #5 clk = ~clk;

  // Multiplier model controls
  bit          mdl_never_busy = 1'b0;
  int          mdl_len_min    = 1;
  int          mdl_bad0       = -1;
  int          mdl_bad1       = -1;
  logic [7:0]  mdl_mask0      = 8'h00;
  logic [7:0]  mdl_mask1      = 8'h00;
  int unsigned pre = 0;
  int unsigned len = 0;
  logic [7:0]  hold  = 8'h00;
  logic [3:0]  lat_a = 4'h0;
  logic [3:0]  lat_b = 4'h0;
  int          stab_err = 0;
  logic [7:0]  starts[$];

  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
    int sa, sb, p;
    sa = int'(a); if (a[3]) sa = sa - 16;
    sb = int'(b); if (b[3]) sb = sb - 16;
    p  = sa * sb;
    return p[7:0];
  endfunction

  function automatic logic [7:0] model_out(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = ref_prod(a, b);
    if (int'({a, b}) == mdl_bad0) p = p ^ mdl_mask0;
    if (int'({a, b}) == mdl_bad1) p = p ^ mdl_mask1;
    return p;
  endfunction

  // Behavioural multiplier: random ack delay 0..3, busy for mdl_len_min..5 cycles,
  // product shows garbage while busy and the (possibly corrupted) result afterwards.
  always @(posedge clk) begin
    if (rst) begin
      mif.mul_busy    <= 1'b0;
      mif.mul_product <= 8'h00;
      pre             <= 0;
      len             <= 0;
    end else begin
      if (mif.mul_busy && (mif.mul_a !== lat_a || mif.mul_b !== lat_b)) stab_err <= stab_err + 1;
      if (mif.mul_start) begin
        starts.push_back({mif.mul_a, mif.mul_b});
        lat_a           <= mif.mul_a;
        lat_b           <= mif.mul_b;
        hold            <= model_out(mif.mul_a, mif.mul_b);
        mif.mul_product <= ~ref_prod(mif.mul_a, mif.mul_b);
        if (!mdl_never_busy) begin : start_blk
          int unsigned d;
          d = $urandom_range(0, 3);
          pre          <= d;
          len          <= $urandom_range(mdl_len_min, 5);
          mif.mul_busy <= (d == 0);
        end
      end else if (pre > 0) begin
        pre <= pre - 1;
        if (pre == 1) mif.mul_busy <= 1'b1;
      end else if (mif.mul_busy) begin
        if (len == 1) begin
          mif.mul_busy    <= 1'b0;
          mif.mul_product <= hold;
        end
        len <= len - 1;
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic end_run();
    test_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; test_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (mif.mul_a !== 4'h0) begin n_bad++; $display("FAIL rst_mul_a: got %0h expected 0", mif.mul_a); end
    n_cmp++; if (mif.mul_b !== 4'h0) begin n_bad++; $display("FAIL rst_mul_b: got %0h expected 0", mif.mul_b); end
    n_cmp++; if (mif.mul_start !== 1'b0) begin n_bad++; $display("FAIL rst_mul_start: got %0b expected 0", mif.mul_start); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b expected 0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL rst_pass: got %0b expected 0", pass); end
    n_cmp++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL rst_err: got %0h expected 0", err_count); end
    n_cmp++; if ({fail_a, fail_b, fail_product} !== 16'h0) begin n_bad++; $display("FAIL rst_fail_regs: got %0h expected 0", {fail_a, fail_b, fail_product}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (starts.size() !== 0) begin n_bad++; $display("FAIL idle_no_start: got %0d expected 0", starts.size()); end
  endtask

  task automatic test_full_run();
    mdl_bad0 = -1; mdl_bad1 = -1; mdl_never_busy = 1'b0; mdl_len_min = 1;
    starts.delete(); stab_err = 0;
    test_en = 1'b1;
    wait_done(6000);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %0b expected 1", done); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL full_pass: got %0b expected 1", pass); end
    n_cmp++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL full_err: got %0h expected 0", err_count); end
    n_cmp++; if (starts.size() !== 256) begin n_bad++; $display("FAIL full_starts: got %0d expected 256", starts.size()); end
    for (int i = 0; i < starts.size() && i < 256; i++) begin
      n_cmp++; if (starts[i] !== 8'(i)) begin n_bad++; $display("FAIL full_order[%0d]: got %0h expected %0h", i, starts[i], 8'(i)); end
    end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL full_operand_stable: got %0d changes expected 0", stab_err); end
    n_cmp++; if ({fail_a, fail_b, fail_product} !== 16'h0) begin n_bad++; $display("FAIL full_fail_regs: got %0h expected 0", {fail_a, fail_b, fail_product}); end
    repeat (5) @(negedge clk);
    n_cmp++; if (done !== 1'b1 || starts.size() !== 256) begin n_bad++; $display("FAIL full_hold: got done=%0b starts=%0d expected done=1 starts=256", done, starts.size()); end
    test_en = 1'b0;
    @(negedge clk);
    n_cmp++; if ({done, pass} !== 2'b00) begin n_bad++; $display("FAIL full_release: got done,pass=%0b expected 00", {done, pass}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mismatch();
    int b0[2], b1[2];
    logic [7:0] m0[2], m1[2];
    logic [7:0] fidx, fmask, exp_err;
    logic [3:0] exp_fa, exp_fb;
    logic [7:0] exp_fp;
    b0[0] = 8'h73; m0[0] = 8'h01; b1[0] = -1; m1[0] = 8'h00;
    b0[1] = $urandom_range(0, 255);
    b1[1] = (b0[1] + $urandom_range(1, 255)) % 256;
    m0[1] = 8'($urandom_range(1, 255));
    m1[1] = 8'($urandom_range(1, 255));
    for (int r = 0; r < 2; r++) begin
      mdl_bad0 = b0[r]; mdl_mask0 = m0[r]; mdl_bad1 = b1[r]; mdl_mask1 = m1[r];
      starts.delete();
      exp_err = (b1[r] < 0) ? 8'd1 : 8'd2;
      if (b1[r] >= 0 && b1[r] < b0[r]) begin fidx = 8'(b1[r]); fmask = m1[r]; end
      else begin fidx = 8'(b0[r]); fmask = m0[r]; end
`ifdef BIST_FAIL_CAPTURE_EN
      exp_fa = fidx[7:4]; exp_fb = fidx[3:0]; exp_fp = ref_prod(fidx[7:4], fidx[3:0]) ^ fmask;
`else
      exp_fa = 4'h0; exp_fb = 4'h0; exp_fp = 8'h00;
`endif
      test_en = 1'b1;
      wait_done(6000);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mm%0d_done: got %0b expected 1", r, done); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL mm%0d_pass: got %0b expected 0", r, pass); end
      n_cmp++; if (err_count !== exp_err) begin n_bad++; $display("FAIL mm%0d_err: got %0h expected %0h", r, err_count, exp_err); end
      n_cmp++; if (fail_a !== exp_fa) begin n_bad++; $display("FAIL mm%0d_fail_a: got %0h expected %0h", r, fail_a, exp_fa); end
      n_cmp++; if (fail_b !== exp_fb) begin n_bad++; $display("FAIL mm%0d_fail_b: got %0h expected %0h", r, fail_b, exp_fb); end
      n_cmp++; if (fail_product !== exp_fp) begin n_bad++; $display("FAIL mm%0d_fail_product: got %0h expected %0h", r, fail_product, exp_fp); end
      end_run();
    end
    mdl_bad0 = -1; mdl_bad1 = -1;
  endtask

  task automatic test_timeout();
    mdl_never_busy = 1'b1;
    starts.delete();
    test_en = 1'b1;
    wait_done(4000);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL tmo_done: got %0b expected 1", done); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL tmo_pass: got %0b expected 0", pass); end
    n_cmp++; if (err_count !== 8'hFF) begin n_bad++; $display("FAIL tmo_err_saturate: got %0h expected ff", err_count); end
    n_cmp++; if (starts.size() !== 256) begin n_bad++; $display("FAIL tmo_starts: got %0d expected 256", starts.size()); end
    n_cmp++; if ({fail_a, fail_b, fail_product} !== 16'h0) begin n_bad++; $display("FAIL tmo_fail_regs: got %0h expected 0", {fail_a, fail_b, fail_product}); end
    end_run();
    mdl_never_busy = 1'b0;
  endtask

  task automatic test_abort();
    int cnt, extra;
    mdl_bad0 = 3; mdl_mask0 = 8'($urandom_range(1, 255));
    starts.delete();
    test_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000 && cnt < 10; i++) begin
      @(negedge clk);
      if (mif.mul_start === 1'b1) cnt++;
    end
    n_cmp++; if (cnt !== 10) begin n_bad++; $display("FAIL abort_reach10: got %0d pulses expected 10", cnt); end
    test_en = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mif.mul_start, done, pass} !== 3'b000) begin n_bad++; $display("FAIL abort_outputs: got start,done,pass=%0b expected 000", {mif.mul_start, done, pass}); end
    extra = 0;
    repeat (12) begin @(negedge clk); if (mif.mul_start === 1'b1) extra++; end
    n_cmp++; if (extra !== 0 || starts.size() !== 10) begin n_bad++; $display("FAIL abort_quiet: got extra=%0d starts=%0d expected 0/10", extra, starts.size()); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL abort_err_kept: got %0h expected 1", err_count); end
    test_en = 1'b1;
    for (int i = 0; i < 20 && mif.mul_start !== 1'b1; i++) @(negedge clk);
    n_cmp++; if ({mif.mul_start, mif.mul_a, mif.mul_b} !== 9'h100) begin n_bad++; $display("FAIL abort_restart_pair: got start,a,b=%0h expected 100", {mif.mul_start, mif.mul_a, mif.mul_b}); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL abort_restart_err: got %0h expected 0", err_count); end
    wait_done(6000);
    n_cmp++; if ({done, pass, err_count} !== 10'h201) begin n_bad++; $display("FAIL abort_rerun: got done,pass,err=%0h expected 201", {done, pass, err_count}); end
    n_cmp++; if (starts.size() !== 266) begin n_bad++; $display("FAIL abort_rerun_starts: got %0d expected 266", starts.size()); end
    end_run();
    mdl_bad0 = -1;
  endtask

  task automatic test_reset_mid_run();
    mdl_bad0 = 1; mdl_mask0 = 8'($urandom_range(1, 255)); mdl_len_min = 3;
    starts.delete();
    test_en = 1'b1;
    for (int i = 0; i < 400 && !(starts.size() >= 5 && mif.mul_busy === 1'b1); i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (err_count !== 8'd1 || mif.mul_busy !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got err=%0h busy=%0b expected 1/1", err_count, mif.mul_busy); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mif.mul_a, mif.mul_b, mif.mul_start, done, pass} !== 11'h0) begin n_bad++; $display("FAIL mid_rst_ctrl: got %0h expected 0", {mif.mul_a, mif.mul_b, mif.mul_start, done, pass}); end
    n_cmp++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL mid_rst_err: got %0h expected 0", err_count); end
    n_cmp++; if ({fail_a, fail_b, fail_product} !== 16'h0) begin n_bad++; $display("FAIL mid_rst_fail_regs: got %0h expected 0", {fail_a, fail_b, fail_product}); end
    rst = 1'b0;
    starts.delete();
    for (int i = 0; i < 20 && starts.size() == 0; i++) @(negedge clk);
    n_cmp++; if (starts.size() == 0 || starts[0] !== 8'h00) begin n_bad++; $display("FAIL mid_fresh_first: got size=%0d expected first pair 00", starts.size()); end
    wait_done(6000);
    n_cmp++; if ({done, pass, err_count} !== 10'h201) begin n_bad++; $display("FAIL mid_fresh_run: got done,pass,err=%0h expected 201", {done, pass, err_count}); end
    n_cmp++; if (starts.size() !== 256) begin n_bad++; $display("FAIL mid_fresh_starts: got %0d expected 256", starts.size()); end
    end_run();
    mdl_bad0 = -1; mdl_len_min = 1;
  endtask

  initial begin
    rst = 1'b1;
    test_en = 1'b0;
    test_reset();
    test_full_run();
    test_mismatch();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
